// File: rtl/sprite_plotter.sv
// Rasterises one garbage-box or press sprite into a VGA pixel port, one pixel per clock,
// behind a start/busy/done handshake. Off-screen pixels are suppressed but still take a cycle.
module sprite_plotter #(
    parameter int         GARB_W     = 20,
    parameter int         GARB_H     = 20,
    parameter int         PRESS_W    = 40,
    parameter int         PRESS_H    = 60,
    parameter int         LANE_X0    = 10,
    parameter int         LANE_PITCH = 36,
    parameter int         GARB_Y     = 80,
    parameter int         PRESS_Y    = 10,
    parameter logic [2:0] GARB_COL   = 3'b010,
    parameter logic [2:0] PRESS_COL  = 3'b111
) (
    input  logic       CLOCK_50,
    input  logic       reset_n,
    input  logic       start,
    input  logic       item,
    input  logic       erase,
    input  logic [2:0] position,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       writeEn,
    output logic       busy,
    output logic       done
);

    localparam int MAX_WH = (GARB_W > GARB_H ? GARB_W : GARB_H) > (PRESS_W > PRESS_H ? PRESS_W : PRESS_H)
                          ? (GARB_W > GARB_H ? GARB_W : GARB_H) : (PRESS_W > PRESS_H ? PRESS_W : PRESS_H);
    localparam int CW = $clog2(MAX_WH + 1);

    typedef enum logic [1:0] {S_IDLE, S_PLOT, S_BAD, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   dx_q, dx_d, dy_q, dy_d;
    logic [CW-1:0]   w_last_q, w_last_d, h_last_q, h_last_d;
    logic [7:0]      ox_q, ox_d;
    logic [6:0]      oy_q, oy_d;
    logic [2:0]      col_q, col_d;
    logic [7:0]      x_q, x_d;
    logic [6:0]      y_q, y_d;
    logic [2:0]      colour_q, colour_d;
    logic            we_q, we_d, busy_q, busy_d, done_q, done_d;

    logic [1:0]      req_lane;
    logic            req_ok;
    logic [8:0]      x_sum;
    logic [7:0]      y_sum;

    // Press steps walk out to lane 3 and back: 0,1,2,3,2,1.
    always_comb begin
        req_lane = position[1:0];
        req_ok   = 1'b1;
        if (item) begin
            case (position)
                3'd4:       req_lane = 2'd2;
                3'd5:       req_lane = 2'd1;
                3'd6, 3'd7: req_ok   = 1'b0;
                default:    ;
            endcase
        end else if (position[2]) begin
            req_ok = 1'b0;
        end
    end

    always_comb begin
        state_d  = state_q;
        dx_d     = dx_q;
        dy_d     = dy_q;
        w_last_d = w_last_q;
        h_last_d = h_last_q;
        ox_d     = ox_q;
        oy_d     = oy_q;
        col_d    = col_q;
        x_d      = x_q;
        y_d      = y_q;
        colour_d = colour_q;
        we_d     = 1'b0;
        busy_d   = busy_q;
        done_d   = 1'b0;
        x_sum    = 9'd0;
        y_sum    = 8'd0;

        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    busy_d   = 1'b1;
                    dx_d     = '0;
                    dy_d     = '0;
                    ox_d     = 8'(LANE_X0) + 8'(LANE_PITCH) * 8'(req_lane);
                    oy_d     = item ? 7'(PRESS_Y) : 7'(GARB_Y);
                    w_last_d = item ? CW'(PRESS_W - 1) : CW'(GARB_W - 1);
                    h_last_d = item ? CW'(PRESS_H - 1) : CW'(GARB_H - 1);
                    col_d    = erase ? 3'b000 : (item ? PRESS_COL : GARB_COL);
                    state_d  = req_ok ? S_PLOT : S_BAD;
                end
            end
            S_PLOT: begin
                if (dx_q == w_last_q) begin
                    dx_d = '0;
                    if (dy_q == h_last_q) begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        dy_d = dy_q + 1'b1;
                    end
                end else begin
                    dx_d = dx_q + 1'b1;
                end
            end
            S_BAD: begin
                state_d = S_DONE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // Outputs are registered, so the pixel for the coming cycle is built from next-state counters.
        if (state_d == S_PLOT) begin
            x_sum    = 9'(ox_d) + 9'(dx_d);
            y_sum    = 8'(oy_d) + 8'(dy_d);
            x_d      = x_sum[7:0];
            y_d      = y_sum[6:0];
            colour_d = col_d;
            we_d     = (x_sum <= 9'd159) && (y_sum <= 8'd119);
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            dx_q     <= '0;
            dy_q     <= '0;
            w_last_q <= '0;
            h_last_q <= '0;
            ox_q     <= '0;
            oy_q     <= '0;
            col_q    <= '0;
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= '0;
            we_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            dx_q     <= dx_d;
            dy_q     <= dy_d;
            w_last_q <= w_last_d;
            h_last_q <= h_last_d;
            ox_q     <= ox_d;
            oy_q     <= oy_d;
            col_q    <= col_d;
            x_q      <= x_d;
            y_q      <= y_d;
            colour_q <= colour_d;
            we_q     <= we_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign x       = x_q;
    assign y       = y_q;
    assign colour  = colour_q;
    assign writeEn = we_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_sprite_plotter.sv
// Directed bench for sprite_plotter: table of sprite requests plus reset, restart and clipping sequences.
module tb_sprite_plotter;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start;
    logic       item;
    logic       erase;
    logic [2:0] position;

    logic [7:0] x1, x2;
    logic [6:0] y1, y2;
    logic [2:0] c1, c2;
    logic       we1, we2, busy1, busy2, done1, done2;

    logic       sel;
    logic [7:0] w_x;
    logic [6:0] w_y;
    logic [2:0] w_col;
    logic       w_we, w_busy, w_done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sprite_plotter dut (
        .CLOCK_50(clk), .reset_n(reset_n), .start(start), .item(item), .erase(erase),
        .position(position), .x(x1), .y(y1), .colour(c1), .writeEn(we1), .busy(busy1), .done(done1)
    );

    sprite_plotter #(.LANE_X0(140)) dut_clip (
        .CLOCK_50(clk), .reset_n(reset_n), .start(start), .item(item), .erase(erase),
        .position(position), .x(x2), .y(y2), .colour(c2), .writeEn(we2), .busy(busy2), .done(done2)
    );

    assign w_x    = sel ? x2    : x1;
    assign w_y    = sel ? y2    : y1;
    assign w_col  = sel ? c2    : c1;
    assign w_we   = sel ? we2   : we1;
    assign w_busy = sel ? busy2 : busy1;
    assign w_done = sel ? done2 : done1;

    typedef struct {
        logic       item;
        logic       erase;
        logic [2:0] pos;
        int         writes;
        int         fx, fy, fcol;
        int         lx, ly;
        int         done_cyc;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Issues one request and watches the selected DUT until done; cycle 1 is the first cycle after start is sampled.
    task automatic run_vec(input vec_t v, input int restart_cyc, input string tag);
        int writes = 0, busy_n = 0, done_cyc = -1;
        int fx = -1, fy = -1, fcol = -1, lx = -1, ly = -1;
        int bad_col = 0, bad_clip = 0, stray = 0;
        @(negedge clk);
        item = v.item; erase = v.erase; position = v.pos; start = 1'b1;
        @(negedge clk);
        start = 1'b0; item = ~v.item; erase = ~v.erase; position = 3'd0;
        for (int c = 1; c <= v.done_cyc + 20 && done_cyc < 0; c++) begin
            if (w_we) begin
                writes++;
                if (fx < 0) begin
                    fx = int'(w_x); fy = int'(w_y); fcol = int'(w_col);
                end
                lx = int'(w_x); ly = int'(w_y);
                if (int'(w_col) != v.fcol) bad_col++;
                if (w_x > 8'd159 || w_y > 7'd119) bad_clip++;
            end
            if (w_busy) busy_n++;
            if (w_done) done_cyc = c;
            start = (c == restart_cyc);
            @(negedge clk);
        end
        start = 1'b0;
        chk({tag, "_writes"}, writes, v.writes);
        chk({tag, "_done_cycle"}, done_cyc, v.done_cyc);
        chk({tag, "_busy_cycles"}, busy_n, v.done_cyc - 1);
        if (v.writes > 0) begin
            chk({tag, "_first_x"}, fx, v.fx);
            chk({tag, "_first_y"}, fy, v.fy);
            chk({tag, "_first_col"}, fcol, v.fcol);
            chk({tag, "_last_x"}, lx, v.lx);
            chk({tag, "_last_y"}, ly, v.ly);
            chk({tag, "_bad_colour_px"}, bad_col, 0);
            chk({tag, "_offscreen_px"}, bad_clip, 0);
            chk({tag, "_hold_x"}, int'(w_x), v.lx);
            chk({tag, "_hold_y"}, int'(w_y), v.ly);
        end
        chk({tag, "_idle_busy"}, int'(w_busy), 0);
        chk({tag, "_done_width"}, int'(w_done), 0);
        for (int k = 0; k < 5; k++) begin
            if (w_we || w_done || w_busy) stray++;
            @(negedge clk);
        end
        chk({tag, "_post_idle_activity"}, stray, 0);
        $display("txn %s writes=%0d first=(%0d,%0d) last=(%0d,%0d) done_at=%0d", tag, writes, fx, fy, lx, ly, done_cyc);
    endtask

    initial begin
        vecs[0] = '{1'b0, 1'b0, 3'd2, 400,  82, 80, 2, 101, 99, 401};
        vecs[1] = '{1'b1, 1'b1, 3'd4, 2400, 82, 10, 0, 121, 69, 2401};
        vecs[2] = '{1'b0, 1'b0, 3'd6, 0,    0,  0,  0, 0,   0,  2};
        vecs[3] = '{1'b0, 1'b0, 3'd3, 400,  118, 80, 2, 137, 99, 401};
        vecs[4] = '{1'b1, 1'b0, 3'd5, 2400, 46, 10, 7, 85,  69, 2401};
        vecs[5] = '{1'b0, 1'b1, 3'd0, 400,  10, 80, 0, 29,  99, 401};
        vecs[6] = '{1'b1, 1'b0, 3'd7, 0,    0,  0,  0, 0,   0,  2};
        vecs[7] = '{1'b1, 1'b0, 3'd0, 2400, 10, 10, 7, 49,  69, 2401};

        sel = 1'b0; reset_n = 1'b0; start = 1'b0; item = 1'b0; erase = 1'b0; position = 3'd0;
        repeat (3) @(negedge clk);
        chk("reset_x", int'(x1), 0);
        chk("reset_y", int'(y1), 0);
        chk("reset_colour", int'(c1), 0);
        chk("reset_writeEn", int'(we1), 0);
        chk("reset_busy", int'(busy1), 0);
        chk("reset_done", int'(done1), 0);
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i], 0, $sformatf("vec%0d", i));
        end

        // A second start during the sweep must be dropped without queueing.
        run_vec(vecs[3], 50, "restart_at_50");

        // Reset in the middle of a press sweep aborts it silently.
        begin
            int stray = 0;
            @(negedge clk);
            item = 1'b1; erase = 1'b0; position = 3'd3; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            repeat (98) @(negedge clk);
            chk("midreset_busy_before", int'(busy1), 1);
            reset_n = 1'b0;
            @(negedge clk);
            chk("midreset_writeEn", int'(we1), 0);
            chk("midreset_busy", int'(busy1), 0);
            chk("midreset_done", int'(done1), 0);
            reset_n = 1'b1;
            for (int k = 0; k < 10; k++) begin
                if (we1 || done1 || busy1) stray++;
                @(negedge clk);
            end
            chk("midreset_no_activity", stray, 0);
            $display("txn midreset stray_cycles=%0d", stray);
        end
        run_vec(vecs[0], 0, "after_reset");

        sel = 1'b1;
        run_vec('{1'b0, 1'b0, 3'd0, 400, 140, 80, 2, 159, 99, 401}, 0, "clip_lane0");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
